// File: rtl/adc_spi3w_master.sv
// adc_spi3w_master: 3-wire SPI master driving a bidirectional SDIO pad for ADC register access
module adc_spi3w_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              csb,
  output logic              sdio_d,
  output logic              sdio_e,
  input  logic              sdio_y
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int BW = $clog2(FW);
  localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_END = 9'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
  localparam logic [BW-1:0] LAST_INST = BW'(ADDR_W);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
  state_t state;
  logic [8:0] cnt;
  logic half;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] sh;
  logic [DATA_W-1:0] rd;
  logic rw;
  logic half_done;
  assign half_done = cnt == HALF_END;
  // frame sequencer: accept, shift out/in MSB first, hold, then enforce the CS gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      half <= 1'b0;
      bit_cnt <= '0;
      sh <= '0;
      rd <= '0;
      rw <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy <= 1'b0;
      sclk <= 1'b0;
      csb <= 1'b1;
      sdio_d <= 1'b0;
      sdio_e <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state <= SHIFT;
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            csb <= 1'b0;
            sdio_e <= 1'b1;
            sdio_d <= cmd_rw;
            sh <= {cmd_addr, cmd_wdata, 1'b0};
            rw <= cmd_rw;
            cnt <= '0;
            half <= 1'b0;
            bit_cnt <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (!half_done) begin
            cnt <= cnt + 9'd1;
          end else begin
            cnt <= '0;
            half <= ~half;
            sclk <= ~half;
            if (half) begin
              if (rw && bit_cnt > LAST_INST) rd <= {rd[DATA_W-2:0], sdio_y};
              if (bit_cnt == LAST_BIT) begin
                state <= HOLD;
                sdio_e <= 1'b0;
                sdio_d <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sdio_d <= sh[FW-1];
                sh <= {sh[FW-2:0], 1'b0};
                if (rw && bit_cnt == LAST_INST) sdio_e <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (!half_done) begin
            cnt <= cnt + 9'd1;
          end else begin
            cnt <= '0;
            state <= GAP;
            csb <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= rw ? rd : '0;
          end
        end
        GAP: begin
          if (cnt != GAP_END) begin
            cnt <= cnt + 9'd1;
          end else begin
            cnt <= '0;
            state <= IDLE;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
